defuse_controller: RTL and testbench

- Sequences a two-digit seconds countdown with keypad code entry for the bomb game.
- Owns the one-second/half-second prescaler and the remaining-time counter.
- Accepts code digits from the keypad front-end and decides ARMED→DEFUSED/EXPLODED.
- Drives BCD digits to two downstream hex drivers, plus status and blink outputs for the display mux.

---
 rtl/defuse_controller.sv | 166 ++++++++++++++++
 tb/tb_defuse_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/defuse_controller.sv
// defuse_controller
//   Countdown/defuse sequencer for the bomb game. Owns the seconds prescaler,
//   the remaining-time register (binary 0..99) and the code-entry tracker.
//
// Ports:
//   clk           in   system clock
//   async_nreset  in   asynchronous, active-low reset
//   start         in   single-cycle arm request (honoured in IDLE/DEFUSED)
//   digit_valid   in   one-cycle keypad strobe
//   digit         in   keypad value, 10..15 never match
//   tens, units   out  BCD of remaining seconds (combinational from register)
//   state         out  0 IDLE, 1 ARMED, 2 DEFUSED, 3 EXPLODED
//   blink         out  explosion blink phase, 0 outside EXPLODED
//   errors        out  wrong-digit count, saturating at 3
//   digit_idx     out  index of the next expected code digit
module defuse_controller #(
    parameter int          CLK_PER_SEC     = 50000000,
    parameter int          START_SECONDS   = 30,
    parameter logic [15:0] CODE            = 16'h1234,
    parameter int          MAX_ERRORS      = 3,
    parameter int          PENALTY_SECONDS = 5
) (
    input  logic       clk,
    input  logic       async_nreset,
    input  logic       start,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic [1:0] state,
    output logic       blink,
    output logic [1:0] errors,
    output logic [1:0] digit_idx
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARMED    = 2'd1,
        S_DEFUSED  = 2'd2,
        S_EXPLODED = 2'd3
    } state_t;

    localparam int             PW        = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0]  PRE_LAST  = PW'(CLK_PER_SEC - 1);
    localparam logic [PW-1:0]  PRE_HALF  = PW'(CLK_PER_SEC / 2 - 1);
    localparam logic [6:0]     START_VAL = 7'(START_SECONDS);
    localparam logic [7:0]     PENALTY   = 8'(PENALTY_SECONDS);

    state_t        state_q, state_d;
    logic [6:0]    rem_q, rem_d;
    logic [1:0]    err_q, err_d;
    logic [1:0]    idx_q, idx_d;
    logic          blink_q, blink_d;
    logic [PW-1:0] pre_q, pre_d;

    logic       running, sec_tick, half_tick;
    logic [3:0] code_nib;
    logic       wrong, hit, err_limit;
    logic [7:0] dec, rem_ext;
    logic [6:0] rem_next;
    logic [1:0] err_inc;

    // Prescaler only runs while the clock is visibly doing something.
    assign running   = (state_q == S_ARMED) || (state_q == S_EXPLODED);
    assign sec_tick  = running && (pre_q == PRE_LAST);
    assign half_tick = running && ((pre_q == PRE_HALF) || (pre_q == PRE_LAST));

    // First code digit lives in the MSB nibble.
    always_comb begin
        code_nib = CODE[15:12];
        case (idx_q)
            2'd0: code_nib = CODE[15:12];
            2'd1: code_nib = CODE[11:8];
            2'd2: code_nib = CODE[7:4];
            2'd3: code_nib = CODE[3:0];
            default: code_nib = CODE[15:12];
        endcase
    end

    assign wrong = digit_valid && (digit != code_nib);
    assign hit   = digit_valid && (digit == code_nib);

    // Tick and penalty combine into a single saturating subtraction.
    assign dec      = {7'd0, sec_tick} + (wrong ? PENALTY : 8'd0);
    assign rem_ext  = {1'b0, rem_q};
    assign rem_next = (rem_ext > dec) ? 7'(rem_ext - dec) : 7'd0;

    assign err_inc   = (err_q == 2'd3) ? 2'd3 : err_q + 2'd1;
    assign err_limit = wrong && ((3'(err_q) + 3'd1) == 3'(MAX_ERRORS));

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state_q <= S_IDLE;
            rem_q   <= START_VAL;
            err_q   <= 2'd0;
            idx_q   <= 2'd0;
            blink_q <= 1'b0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            blink_q <= blink_d;
            pre_q   <= pre_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        err_d   = err_q;
        idx_d   = idx_q;
        blink_d = 1'b0;
        pre_d   = '0;
        if (running) pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;

        case (state_q)
            S_IDLE, S_DEFUSED: begin
                // Arming reloads everything and restarts the prescaler phase.
                if (start) begin
                    state_d = S_ARMED;
                    rem_d   = START_VAL;
                    err_d   = 2'd0;
                    idx_d   = 2'd0;
                    pre_d   = '0;
                end
            end
            S_ARMED: begin
                if (hit && idx_q == 2'd3) begin
                    // Final digit wins over a same-cycle tick: time is frozen as-is.
                    state_d = S_DEFUSED;
                    idx_d   = idx_q + 2'd1;
                end else begin
                    if (wrong) begin
                        idx_d = 2'd0;
                        err_d = err_inc;
                    end else if (hit) begin
                        idx_d = idx_q + 2'd1;
                    end
                    if (rem_next == 7'd0 || err_limit) begin
                        state_d = S_EXPLODED;
                        rem_d   = 7'd0;
                        pre_d   = '0;
                        blink_d = 1'b1;
                    end else begin
                        rem_d = rem_next;
                    end
                end
            end
            S_EXPLODED: begin
                rem_d   = 7'd0;
                blink_d = half_tick ? ~blink_q : blink_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state     = state_q;
    assign tens      = 4'(rem_q / 7'd10);
    assign units     = 4'(rem_q % 7'd10);
    assign blink     = blink_q;
    assign errors    = err_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_defuse_controller.sv
module tb_defuse_controller;

    logic       clk = 1'b0;
    logic       async_nreset = 1'b1;
    logic       start = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic [3:0] tens, units;
    logic [1:0] state;
    logic       blink;
    logic [1:0] errors;
    logic [1:0] digit_idx;

    int n_checks = 0;
    int n_fail   = 0;

    defuse_controller #(
        .CLK_PER_SEC(4), .START_SECONDS(12), .CODE(16'h1234),
        .MAX_ERRORS(3), .PENALTY_SECONDS(5)
    ) dut (
        .clk(clk), .async_nreset(async_nreset), .start(start),
        .digit_valid(digit_valid), .digit(digit),
        .tens(tens), .units(units), .state(state), .blink(blink),
        .errors(errors), .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         rst;
        bit         st;
        bit         dv;
        logic [3:0] dg;
        int         n;
        logic [1:0] e_state;
        logic [3:0] e_tens;
        logic [3:0] e_units;
        logic [1:0] e_err;
        logic [1:0] e_idx;
        bit         e_blink;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit st, bit dv, logic [3:0] dg, int n,
                                logic [1:0] es, logic [3:0] et, logic [3:0] eu,
                                logic [1:0] ee, logic [1:0] ei, bit eb, string tag);
        vec_t v;
        v.rst = rst; v.st = st; v.dv = dv; v.dg = dg; v.n = n;
        v.e_state = es; v.e_tens = et; v.e_units = eu;
        v.e_err = ee; v.e_idx = ei; v.e_blink = eb; v.tag = tag;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] es, input logic [3:0] et,
                             input logic [3:0] eu, input logic [1:0] ee, input logic [1:0] ei,
                             input bit eb);
        check({tag, ".state"},     8'(state),     8'(es));
        check({tag, ".tens"},      8'(tens),      8'(et));
        check({tag, ".units"},     8'(units),     8'(eu));
        check({tag, ".errors"},    8'(errors),    8'(ee));
        check({tag, ".digit_idx"}, 8'(digit_idx), 8'(ei));
        check({tag, ".blink"},     8'(blink),     8'(eb));
    endtask

    // One clock: drive, take the edge, settle, clear strobes.
    task automatic cyc(input bit st, input bit dv, input logic [3:0] dg);
        start = st; digit_valid = dv; digit = dg;
        @(posedge clk);
        #1;
        start = 1'b0; digit_valid = 1'b0; digit = 4'd0;
    endtask

    // Called 1ns after an edge; reset pulse ends well before the next edge.
    task automatic pulse_reset();
        async_nreset = 1'b0;
        #2;
        async_nreset = 1'b1;
    endtask

    initial begin
        // ---- async reset values, before any clock edge ----
        #2 async_nreset = 1'b0;
        #1;
        check_all("reset", 2'd0, 4'd1, 4'd2, 2'd0, 2'd0, 1'b0);
        @(posedge clk);
        #1 async_nreset = 1'b1;

        // ---- countdown to zero, then blink, then async abort ----
        cyc(1, 0, 0);
        check_all("t1_arm", 2'd1, 4'd1, 4'd2, 2'd0, 2'd0, 1'b0);
        repeat (3) cyc(0, 0, 0);
        check_all("t1_pre_tick", 2'd1, 4'd1, 4'd2, 2'd0, 2'd0, 1'b0);
        cyc(0, 0, 0);
        check_all("t1_first_tick", 2'd1, 4'd1, 4'd1, 2'd0, 2'd0, 1'b0);
        repeat (40) cyc(0, 0, 0);
        check_all("t1_at_01", 2'd1, 4'd0, 4'd1, 2'd0, 2'd0, 1'b0);
        repeat (3) cyc(0, 0, 0);
        check_all("t1_hold_01", 2'd1, 4'd0, 4'd1, 2'd0, 2'd0, 1'b0);
        cyc(0, 0, 0);
        check_all("t1_timeout", 2'd3, 4'd0, 4'd0, 2'd0, 2'd0, 1'b1);
        begin
            bit exp_blink [8] = '{1, 0, 0, 1, 1, 0, 0, 1};
            for (int i = 0; i < 8; i++) begin
                cyc(i[0], i[1], 4'(i + 1));
                check_all($sformatf("t6_blink%0d", i), 2'd3, 4'd0, 4'd0, 2'd0, 2'd0, exp_blink[i]);
            end
        end
        cyc(0, 0, 0);
        #2 async_nreset = 1'b0;
        #1;
        check_all("t6_async_abort", 2'd0, 4'd1, 4'd2, 2'd0, 2'd0, 1'b0);
        @(posedge clk);
        #1 async_nreset = 1'b1;

        // ---- table-driven sequences ----
        // correct code, defuse-on-tick, re-arm, wrong digits to explosion
        vecs.push_back(mk(1, 0, 1, 4'd1,  1, 2'd0, 4'd1, 4'd2, 2'd0, 2'd0, 0, "idle_ignores_digit"));
        vecs.push_back(mk(0, 1, 0, 4'd0,  1, 2'd1, 4'd1, 4'd2, 2'd0, 2'd0, 0, "arm"));
        vecs.push_back(mk(0, 0, 1, 4'd1,  1, 2'd1, 4'd1, 4'd2, 2'd0, 2'd1, 0, "code_d1"));
        vecs.push_back(mk(0, 0, 1, 4'd2,  1, 2'd1, 4'd1, 4'd2, 2'd0, 2'd2, 0, "code_d2"));
        vecs.push_back(mk(0, 0, 1, 4'd3,  1, 2'd1, 4'd1, 4'd2, 2'd0, 2'd3, 0, "code_d3"));
        vecs.push_back(mk(0, 0, 1, 4'd4,  1, 2'd2, 4'd1, 4'd2, 2'd0, 2'd0, 0, "defuse_on_tick"));
        vecs.push_back(mk(0, 0, 0, 4'd0, 20, 2'd2, 4'd1, 4'd2, 2'd0, 2'd0, 0, "defused_frozen"));
        vecs.push_back(mk(0, 0, 1, 4'd7,  1, 2'd2, 4'd1, 4'd2, 2'd0, 2'd0, 0, "defused_ignores_digit"));
        vecs.push_back(mk(0, 1, 0, 4'd0,  1, 2'd1, 4'd1, 4'd2, 2'd0, 2'd0, 0, "rearm"));
        vecs.push_back(mk(0, 0, 1, 4'd7,  1, 2'd1, 4'd0, 4'd7, 2'd1, 2'd0, 0, "wrong_penalty"));
        vecs.push_back(mk(0, 0, 1, 4'd1,  1, 2'd1, 4'd0, 4'd7, 2'd1, 2'd1, 0, "partial_d1"));
        vecs.push_back(mk(0, 0, 1, 4'd9,  1, 2'd1, 4'd0, 4'd2, 2'd2, 2'd0, 0, "wrong_resets_idx"));
        vecs.push_back(mk(0, 0, 1, 4'd15, 1, 2'd3, 4'd0, 4'd0, 2'd3, 2'd0, 1, "max_errors"));
        // wrong digit coinciding with a tick
        vecs.push_back(mk(1, 1, 0, 4'd0,  1, 2'd1, 4'd1, 4'd2, 2'd0, 2'd0, 0, "arm4a"));
        vecs.push_back(mk(0, 0, 0, 4'd0, 19, 2'd1, 4'd0, 4'd8, 2'd0, 2'd0, 0, "count_to_8"));
        vecs.push_back(mk(0, 0, 1, 4'd0,  1, 2'd1, 4'd0, 4'd2, 2'd1, 2'd0, 0, "wrong_on_tick"));
        vecs.push_back(mk(1, 1, 0, 4'd0,  1, 2'd1, 4'd1, 4'd2, 2'd0, 2'd0, 0, "arm4b"));
        vecs.push_back(mk(0, 0, 0, 4'd0, 39, 2'd1, 4'd0, 4'd3, 2'd0, 2'd0, 0, "count_to_3"));
        vecs.push_back(mk(0, 0, 1, 4'd5,  1, 2'd3, 4'd0, 4'd0, 2'd1, 2'd0, 1, "wrong_on_tick_sat"));
        // final digit on the tick that would otherwise reach zero
        vecs.push_back(mk(1, 1, 0, 4'd0,  1, 2'd1, 4'd1, 4'd2, 2'd0, 2'd0, 0, "arm5"));
        vecs.push_back(mk(0, 0, 0, 4'd0, 43, 2'd1, 4'd0, 4'd2, 2'd0, 2'd0, 0, "count_to_2"));
        vecs.push_back(mk(0, 1, 0, 4'd0,  1, 2'd1, 4'd0, 4'd1, 2'd0, 2'd0, 0, "armed_ignores_start"));
        vecs.push_back(mk(0, 0, 1, 4'd1,  1, 2'd1, 4'd0, 4'd1, 2'd0, 2'd1, 0, "late_d1"));
        vecs.push_back(mk(0, 0, 1, 4'd2,  1, 2'd1, 4'd0, 4'd1, 2'd0, 2'd2, 0, "late_d2"));
        vecs.push_back(mk(0, 0, 1, 4'd3,  1, 2'd1, 4'd0, 4'd1, 2'd0, 2'd3, 0, "late_d3"));
        vecs.push_back(mk(0, 0, 1, 4'd4,  1, 2'd2, 4'd0, 4'd1, 2'd0, 2'd0, 0, "defuse_beats_tick"));
        vecs.push_back(mk(0, 0, 0, 4'd0,  4, 2'd2, 4'd0, 4'd1, 2'd0, 2'd0, 0, "defused_hold"));

        foreach (vecs[i]) begin
            if (vecs[i].rst) pulse_reset();
            repeat (vecs[i].n) cyc(vecs[i].st, vecs[i].dv, vecs[i].dg);
            check_all(vecs[i].tag, vecs[i].e_state, vecs[i].e_tens, vecs[i].e_units,
                      vecs[i].e_err, vecs[i].e_idx, vecs[i].e_blink);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
